// File: rtl/stp_pkg.sv
// Shared types and geometry helpers for the framed serial-to-parallel assembler.
package stp_pkg;

  typedef enum logic [1:0] {
    S_N    = 2'd0,
    S_E    = 2'd1,
    S_MSG  = 2'd2,
    S_HOLD = 2'd3
  } stp_state_e;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_w(input int v);
    if (v < 2) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

  function automatic int bytes_per_op(input int n);
    return n / 8;
  endfunction

  function automatic int chunks_per_op(input int n, input int dbits);
    return n / dbits;
  endfunction

  function automatic int bytes_per_chunk(input int dbits);
    return dbits / 8;
  endfunction

endpackage

// File: rtl/serial_to_parallel_framed_byte_bitstats.sv
// Combinational per-byte statistics: nonzero flag, index of the top set bit, popcount.
module byte_bitstats (
  input  logic [7:0] byte_i,
  output logic       nz_o,
  output logic [2:0] msb_o,
  output logic [3:0] pop_o
);

  // Ascending scan so the last set bit seen is the most significant one.
  always_comb begin
    msb_o = 3'd0;
    pop_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (byte_i[i]) begin
        msb_o = 3'(i);
        pop_o = pop_o + 4'd1;
      end else begin
        pop_o = pop_o;
      end
    end
  end

  assign nz_o = |byte_i;

endmodule

// File: rtl/serial_to_parallel_framed.sv
// Assembles a UART byte stream into an RSA job frame (n, e, message blocks) with
// on-the-fly exponent statistics, BRAM write-out, ack handshake, timeout and overrun.
module serial_to_parallel_framed
  import stp_pkg::*;
#(
  parameter int N         = 64,
  parameter int NLOG2     = 6,
  parameter int DBITS     = 64,
  parameter int ABITS     = 8,
  parameter int NUM_MSG   = 1,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  input  logic               tx_ack,
  output logic               tx_valid,
  output logic [N-1:0]       tx_n,
  output logic [N-1:0]       tx_e,
  output logic [NLOG2-1:0]   tx_e_idx,
  output logic [NLOG2:0]     tx_mp_count,
  output logic [ABITS-1:0]   wr_addr,
  output logic [DBITS-1:0]   wr_data,
  output logic               wr_en,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int BYTES_PER_OP    = bytes_per_op(N);
  localparam int CHUNKS_PER_OP   = chunks_per_op(N, DBITS);
  localparam int BYTES_PER_CHUNK = bytes_per_chunk(DBITS);
  localparam int BW  = cnt_w(BYTES_PER_OP);
  localparam int CW  = cnt_w(CHUNKS_PER_OP);
  localparam int KW  = cnt_w(NUM_MSG);
  localparam int TW  = cnt_w(TIMEOUT + 1);
  localparam int MPW = NLOG2 + 1;
  localparam int TIMEOUT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  stp_state_e       state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;
  logic [KW-1:0]    kcnt_q, kcnt_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic [N-1:0]     n_q, n_d, e_q, e_d;
  logic [DBITS-1:0] chunk_q, chunk_d;
  logic [NLOG2-1:0] eidx_q, eidx_d;
  logic [MPW-1:0]   mp_q, mp_d;
  logic             seen_q, seen_d;

  logic             tx_valid_q, tx_valid_d;
  logic [N-1:0]     tx_n_q, tx_n_d, tx_e_q, tx_e_d;
  logic [NLOG2-1:0] tx_eidx_q, tx_eidx_d;
  logic [MPW-1:0]   tx_mp_q, tx_mp_d;
  logic [ABITS-1:0] wr_addr_q, wr_addr_d;
  logic [DBITS-1:0] wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic             nz_s;
  logic [2:0]       msb_s;
  logic [3:0]       pop_s;
  logic [BW-1:0]    r_s;
  logic [DBITS-1:0] chunk_next_s;
  logic             started_s;

  byte_bitstats u_bitstats (
    .byte_i (rx_byte),
    .nz_o   (nz_s),
    .msb_o  (msb_s),
    .pop_o  (pop_s)
  );

  assign r_s          = BW'(BYTES_PER_OP - 1) - bcnt_q;
  assign chunk_next_s = DBITS'({chunk_q, rx_byte});
  assign started_s    = (state_q != S_N) || (bcnt_q != '0);

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d       = state_q;
    bcnt_d        = bcnt_q;
    ccnt_d        = ccnt_q;
    kcnt_d        = kcnt_q;
    idle_d        = idle_q;
    n_d           = n_q;
    e_d           = e_q;
    chunk_d       = chunk_q;
    eidx_d        = eidx_q;
    mp_d          = mp_q;
    seen_d        = seen_q;
    tx_valid_d    = tx_valid_q;
    tx_n_d        = tx_n_q;
    tx_e_d        = tx_e_q;
    tx_eidx_d     = tx_eidx_q;
    tx_mp_d       = tx_mp_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 1'b0;
    overrun_d     = overrun_q;
    timeout_err_d = 1'b0;

    case (state_q)
      S_N: begin
        if (rx_valid) begin
          n_d = N'({n_q, rx_byte});
          if (bcnt_q == BW'(BYTES_PER_OP - 1)) begin
            bcnt_d  = '0;
            state_d = S_E;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          n_d = n_q;
        end
      end
      S_E: begin
        if (rx_valid) begin
          e_d  = N'({e_q, rx_byte});
          mp_d = mp_q + MPW'(pop_s);
          // First nonzero byte fixes the top-bit index; r is bytes still to come.
          if (!seen_q && nz_s) begin
            seen_d = 1'b1;
            eidx_d = NLOG2'({r_s, msb_s});
          end else begin
            seen_d = seen_q;
          end
          if (bcnt_q == BW'(BYTES_PER_OP - 1)) begin
            bcnt_d  = '0;
            state_d = S_MSG;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          e_d = e_q;
        end
      end
      S_MSG: begin
        if (rx_valid) begin
          chunk_d = chunk_next_s;
          if (bcnt_q == BW'(BYTES_PER_CHUNK - 1)) begin
            bcnt_d    = '0;
            wr_en_d   = 1'b1;
            wr_data_d = chunk_next_s;
            wr_addr_d = ABITS'(BASE_ADDR + int'(kcnt_q) * CHUNKS_PER_OP
                               + CHUNKS_PER_OP - 1 - int'(ccnt_q));
            if (ccnt_q == CW'(CHUNKS_PER_OP - 1)) begin
              ccnt_d = '0;
              if (kcnt_q == KW'(NUM_MSG - 1)) begin
                kcnt_d     = '0;
                state_d    = S_HOLD;
                tx_valid_d = 1'b1;
                tx_n_d     = n_q;
                tx_e_d     = e_q;
                tx_eidx_d  = eidx_q;
                tx_mp_d    = mp_q;
              end else begin
                kcnt_d = kcnt_q + 1'b1;
              end
            end else begin
              ccnt_d = ccnt_q + 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          chunk_d = chunk_q;
        end
      end
      S_HOLD: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (tx_ack) begin
          tx_valid_d = 1'b0;
          state_d    = S_N;
          bcnt_d     = '0;
          ccnt_d     = '0;
          kcnt_d     = '0;
          seen_d     = 1'b0;
          eidx_d     = '0;
          mp_d       = '0;
        end else begin
          tx_valid_d = tx_valid_q;
        end
      end
      default: begin
        state_d = S_N;
      end
    endcase

    // Idle watchdog: only mid-frame, and an arriving byte always wins over expiry.
    if ((TIMEOUT > 0) && (state_q != S_HOLD) && started_s && !rx_valid) begin
      if (idle_q == TW'(TIMEOUT_LAST)) begin
        idle_d        = '0;
        timeout_err_d = 1'b1;
        state_d       = S_N;
        bcnt_d        = '0;
        ccnt_d        = '0;
        kcnt_d        = '0;
        seen_d        = 1'b0;
        eidx_d        = '0;
        mp_d          = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_N;
      bcnt_q        <= '0;
      ccnt_q        <= '0;
      kcnt_q        <= '0;
      idle_q        <= '0;
      n_q           <= '0;
      e_q           <= '0;
      chunk_q       <= '0;
      eidx_q        <= '0;
      mp_q          <= '0;
      seen_q        <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_n_q        <= '0;
      tx_e_q        <= '0;
      tx_eidx_q     <= '0;
      tx_mp_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      ccnt_q        <= ccnt_d;
      kcnt_q        <= kcnt_d;
      idle_q        <= idle_d;
      n_q           <= n_d;
      e_q           <= e_d;
      chunk_q       <= chunk_d;
      eidx_q        <= eidx_d;
      mp_q          <= mp_d;
      seen_q        <= seen_d;
      tx_valid_q    <= tx_valid_d;
      tx_n_q        <= tx_n_d;
      tx_e_q        <= tx_e_d;
      tx_eidx_q     <= tx_eidx_d;
      tx_mp_q       <= tx_mp_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_n        = tx_n_q;
  assign tx_e        = tx_e_q;
  assign tx_e_idx    = tx_eidx_q;
  assign tx_mp_count = tx_mp_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_en       = wr_en_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_to_parallel_framed.sv
// Directed bench: instance A (DBITS=32, one block, TIMEOUT=16), instance B (DBITS=64, two blocks).
module tb_serial_to_parallel_framed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;
  logic        tx_ack_a = 1'b0, tx_ack_b = 1'b0;

  logic        tx_valid_a, tx_valid_b;
  logic [63:0] tx_n_a, tx_e_a, tx_n_b, tx_e_b;
  logic [5:0]  tx_e_idx_a, tx_e_idx_b;
  logic [6:0]  tx_mp_a, tx_mp_b;
  logic [7:0]  wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a;
  logic [63:0] wr_data_b;
  logic        wr_en_a, wr_en_b, overrun_a, overrun_b, to_a, to_b;

  int n_cmp = 0;
  int n_mis = 0;
  int to_cnt_a = 0;

  logic [7:0]  wa_addr[$];
  logic [31:0] wa_data[$];
  logic [7:0]  wb_addr[$];
  logic [63:0] wb_data[$];

  always #5 clk = ~clk;

  serial_to_parallel_framed #(
    .N(64), .NLOG2(6), .DBITS(32), .ABITS(8), .NUM_MSG(1), .BASE_ADDR(0), .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .rx_byte(rx_byte), .tx_ack(tx_ack_a),
    .tx_valid(tx_valid_a), .tx_n(tx_n_a), .tx_e(tx_e_a), .tx_e_idx(tx_e_idx_a),
    .tx_mp_count(tx_mp_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
    .overrun(overrun_a), .timeout_err(to_a)
  );

  serial_to_parallel_framed #(
    .N(64), .NLOG2(6), .DBITS(64), .ABITS(8), .NUM_MSG(2), .BASE_ADDR(0), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .rx_byte(rx_byte), .tx_ack(tx_ack_b),
    .tx_valid(tx_valid_b), .tx_n(tx_n_b), .tx_e(tx_e_b), .tx_e_idx(tx_e_idx_b),
    .tx_mp_count(tx_mp_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
    .overrun(overrun_b), .timeout_err(to_b)
  );

  // BRAM write and timeout-pulse capture.
  always @(negedge clk) begin
    if (wr_en_a) begin
      wa_addr.push_back(wr_addr_a);
      wa_data.push_back(wr_data_a);
    end
    if (wr_en_b) begin
      wb_addr.push_back(wr_addr_b);
      wb_data.push_back(wr_data_b);
    end
    if (to_a) to_cnt_a++;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic put_byte(input bit sel, input logic [7:0] b);
    @(negedge clk);
    rx_byte    = b;
    rx_valid_a = !sel;
    rx_valid_b = sel;
  endtask

  task automatic put_word(input bit sel, input logic [63:0] w);
    for (int i = 7; i >= 0; i--) put_byte(sel, w[i*8 +: 8]);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
    end
  endtask

  task automatic ack(input bit sel);
    @(negedge clk);
    tx_ack_a = !sel;
    tx_ack_b = sel;
    @(negedge clk);
    tx_ack_a = 1'b0;
    tx_ack_b = 1'b0;
  endtask

  // Sends a full frame back-to-back and checks the delivered tx_* fields.
  task automatic send_frame(input bit sel, input logic [63:0] n, input logic [63:0] e,
                            input logic [63:0] m0, input logic [63:0] m1,
                            input int exp_idx, input int exp_mp);
    logic [63:0] last;
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    put_word(sel, n);
    put_word(sel, e);
    if (sel) begin
      put_word(sel, m0);
      last = m1;
    end else begin
      last = m0;
    end
    for (int i = 7; i >= 1; i--) put_byte(sel, last[i*8 +: 8]);
    put_byte(sel, last[7:0]);
    check_eq("tx_valid_pre", sel ? tx_valid_b : tx_valid_a, 1'b0);
    idle(1);
    check_eq("tx_valid_post", sel ? tx_valid_b : tx_valid_a, 1'b1);
    check_eq("tx_n", sel ? tx_n_b : tx_n_a, n);
    check_eq("tx_e", sel ? tx_e_b : tx_e_a, e);
    check_eq("tx_e_idx", sel ? tx_e_idx_b : tx_e_idx_a, exp_idx);
    check_eq("tx_mp_count", sel ? tx_mp_b : tx_mp_a, exp_mp);
    idle(1);
  endtask

  task automatic chk_writes_a(input logic [63:0] m);
    check_eq("a_wr_count", wa_addr.size(), 2);
    if (wa_addr.size() == 2) begin
      check_eq("a_wr0_addr", wa_addr[0], 8'd1);
      check_eq("a_wr0_data", wa_data[0], m[63:32]);
      check_eq("a_wr1_addr", wa_addr[1], 8'd0);
      check_eq("a_wr1_data", wa_data[1], m[31:0]);
    end
  endtask

  initial begin
    // Reset state
    idle(3);
    check_eq("rst_tx_valid", tx_valid_a, 1'b0);
    check_eq("rst_tx_n", tx_n_a, 64'd0);
    check_eq("rst_wr_en", wr_en_a, 1'b0);
    check_eq("rst_overrun", overrun_a, 1'b0);
    check_eq("rst_timeout", to_a, 1'b0);
    rst = 1'b0;
    idle(2);

    // Scenario 1: basic frame, hold until ack
    send_frame(1'b0, 64'hAABBCCDD11223344, 64'h0000000000010001,
               64'h0123456789ABCDEF, 64'h0, 16, 2);
    chk_writes_a(64'h0123456789ABCDEF);
    idle(5);
    check_eq("s1_hold_valid", tx_valid_a, 1'b1);
    ack(1'b0);
    check_eq("s1_ack_clears", tx_valid_a, 1'b0);
    check_eq("s1_tx_n_kept", tx_n_a, 64'hAABBCCDD11223344);
    check_eq("s1_no_timeout", to_cnt_a, 0);

    // Scenario 2: zero exponent
    send_frame(1'b0, 64'h1122334455667788, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 0);
    chk_writes_a(64'hDEADBEEFCAFEF00D);
    ack(1'b0);

    // Scenario 3: all-ones exponent
    send_frame(1'b0, 64'h0F0E0D0C0B0A0908, 64'hFFFFFFFFFFFFFFFF,
               64'h0011223344556677, 64'h0, 63, 64);
    ack(1'b0);

    // Scenario 4: 10 bytes then idle until the watchdog fires
    put_word(1'b0, 64'h5555555555555555);
    put_byte(1'b0, 8'h00);
    put_byte(1'b0, 8'h80);
    idle(16);
    check_eq("s4_no_early_to", to_a, 1'b0);
    idle(1);
    check_eq("s4_to_pulse", to_a, 1'b1);
    idle(1);
    check_eq("s4_to_one_cycle", to_a, 1'b0);
    idle(5);
    check_eq("s4_to_count", to_cnt_a, 1);
    send_frame(1'b0, 64'hAABBCCDD11223344, 64'h0000000000010001,
               64'h0123456789ABCDEF, 64'h0, 16, 2);
    chk_writes_a(64'h0123456789ABCDEF);

    // Scenario 5: bytes during hold, ack coincident with a third byte
    put_byte(1'b0, 8'h55);
    put_byte(1'b0, 8'h66);
    @(negedge clk);
    rx_byte = 8'h77; rx_valid_a = 1'b1; tx_ack_a = 1'b1;
    @(negedge clk);
    rx_valid_a = 1'b0; tx_ack_a = 1'b0;
    check_eq("s5_valid_low", tx_valid_a, 1'b0);
    check_eq("s5_overrun", overrun_a, 1'b1);
    check_eq("s5_tx_n", tx_n_a, 64'hAABBCCDD11223344);
    check_eq("s5_tx_e", tx_e_a, 64'h0000000000010001);
    send_frame(1'b0, 64'h1122334455667788, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h0, 0, 0);
    check_eq("s5_overrun_sticky", overrun_a, 1'b1);
    ack(1'b0);

    // Scenario 6: two 64-bit blocks, then reset mid-frame and recover
    send_frame(1'b1, 64'h0102030405060708, 64'h8000000000000000,
               64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 63, 1);
    check_eq("b_wr_count", wb_addr.size(), 2);
    if (wb_addr.size() == 2) begin
      check_eq("b_wr0_addr", wb_addr[0], 8'd0);
      check_eq("b_wr0_data", wb_data[0], 64'h0123456789ABCDEF);
      check_eq("b_wr1_addr", wb_addr[1], 8'd1);
      check_eq("b_wr1_data", wb_data[1], 64'hFEDCBA9876543210);
    end
    ack(1'b1);
    put_word(1'b1, 64'h1111111111111111);
    put_byte(1'b1, 8'h01);
    put_byte(1'b1, 8'h02);
    put_byte(1'b1, 8'h03);
    @(negedge clk);
    rx_valid_b = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("b_rst_tx_n", tx_n_b, 64'd0);
    check_eq("b_rst_tx_e", tx_e_b, 64'd0);
    check_eq("b_rst_idx_mp", {tx_e_idx_b, tx_mp_b}, 13'd0);
    check_eq("b_rst_wr", {wr_en_b, wr_addr_b, wr_data_b}, 73'd0);
    check_eq("b_rst_flags", {tx_valid_b, overrun_b, to_b}, 3'd0);
    check_eq("a_rst_overrun", overrun_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    send_frame(1'b1, 64'hAABBCCDD11223344, 64'h00000000000000F0,
               64'h1122334455667788, 64'h99AABBCCDDEEFF00, 7, 4);
    check_eq("b2_wr_count", wb_addr.size(), 2);
    if (wb_addr.size() == 2) begin
      check_eq("b2_wr0_data", wb_data[0], 64'h1122334455667788);
      check_eq("b2_wr1_addr", wb_addr[1], 8'd1);
    end
    ack(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_framed.md
Name: serial_to_parallel_framed

Overview:
Parametrised successor to serial_to_parallel. Assembles a UART byte stream into one RSA job frame: modulus n, exponent e, then NUM_MSG N-bit message blocks. Message blocks are written into BRAM as DBITS words. n and e go to mon_exp together with exponent statistics (e_idx, mp_count), which are computed on the fly. Adds the following over the previous block:
- level-held tx_valid with tx_ack handshake
- inter-byte timeout
- overrun detection
- multi-block message support

Parameters:
- N, 64, operand width in bits; multiple of DBITS.
- NLOG2, 6, log2(N).
- DBITS, 64, BRAM data width; multiple of 8.
- ABITS, 8, BRAM address width.
- NUM_MSG, 1, N-bit message blocks per frame (>=1).
- BASE_ADDR, 0, BRAM address of message block 0, least-significant word.
- TIMEOUT, 0, idle cycles mid-frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  rx_byte valid this cycle (single-cycle strobe from UART RX).
- rx_byte  in  8  received byte.
- tx_ack  in  1  downstream has consumed the frame.
- tx_valid  out  1  frame complete; held until tx_ack.
- tx_n  out  N  modulus.
- tx_e  out  N  exponent.
- tx_e_idx  out  NLOG2  index of the most significant set bit of e.
- tx_mp_count  out  NLOG2+1  popcount of e.
- wr_addr  out  ABITS  BRAM write address.
- wr_data  out  DBITS  BRAM write data.
- wr_en  out  1  BRAM write strobe.
- overrun  out  1  sticky: a byte arrived during HOLD.
- timeout_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, immediate): every output is 0. State S_N, all counters 0.
- Frame layout: N/8 bytes of n, then N/8 bytes of e, then NUM_MSG*N/8 message bytes. Every field is sent MSB byte first.
- S_N: shift rx_byte into the n register, LSB side. After N/8 bytes, go to S_E.
- S_E: shift bytes into the e register. Per byte, using the remaining-byte count r (counts down N/8-1..0):
  - If no set bit has been seen yet and the byte is nonzero, e_idx = 8*r + msb(byte).
  - mp_count += popcount(byte).
  - After the last e byte, go to S_MSG.
- S_MSG: shift bytes into a DBITS chunk register. Each time DBITS/8 bytes complete a chunk:
  - wr_en pulses for 1 cycle, in the cycle after the completing byte.
  - wr_data = the chunk.
  - wr_addr = BASE_ADDR + k*(N/DBITS) + (N/DBITS-1-c), where k is the block index and c is the chunk arrival index within the block. The most significant chunk arrives first and lands at the highest address.
  - After the last byte of the last block, go to S_HOLD.
- S_HOLD:
  - tx_valid = 1 from the cycle after the final byte; this is the same cycle as the final wr_en.
  - tx_n, tx_e, tx_e_idx and tx_mp_count are stable while tx_valid = 1.
  - tx_ack sampled high clears tx_valid on the next cycle and returns to S_N. All counters clear. Output registers keep their values until overwritten by the next frame.
- e == 0: tx_e_idx = 0, tx_mp_count = 0. The frame is still delivered.
- Overrun: any rx_valid in S_HOLD sets overrun, including the tx_ack cycle. The byte is dropped and tx_* is unchanged. overrun clears only on rst.
- Timeout (TIMEOUT > 0):
  - An idle counter runs only when the state is not S_HOLD and at least one byte of the current frame has been received.
  - It resets on every rx_valid.
  - When it reaches TIMEOUT: timeout_err pulses 1 cycle, state returns to S_N with counters cleared.
  - BRAM words already written are not rolled back.
  - An rx_valid in the expiry cycle wins: the byte is accepted and there is no timeout.
- Byte acceptance is 1 per cycle and back-to-back rx_valid is legal. No other latency applies.

Decomposition:
- Package stp_pkg holds:
  - state enum {S_N, S_E, S_MSG, S_HOLD}
  - localparams BYTES_PER_OP = N/8, CHUNKS_PER_OP = N/DBITS, BYTES_PER_CHUNK = DBITS/8
  - counter widths derived via $clog2
- One sub-module, byte_bitstats: combinational 8-bit priority encoder plus popcount. Outputs nz, msb[2:0], pop[3:0].
- The FSM, shift registers, address generation and timeout counter live in the top.

Test Plan:
All scenarios use N=64, NLOG2=6, DBITS=32, NUM_MSG=1 and BASE_ADDR=0 unless stated.
1. Send n=AABBCCDD11223344, e=0000000000010001, msg=0123456789ABCDEF, back-to-back 24 bytes -> expected:
   - wr addr1=01234567, then addr0=89ABCDEF
   - tx_valid 1 cycle after byte 24
   - tx_e_idx=16, tx_mp_count=2
   - tx_valid stays high until tx_ack.
2. e=0 -> tx_e_idx=0, tx_mp_count=0, tx_valid asserted normally.
3. e=FFFFFFFFFFFFFFFF -> tx_e_idx=63, tx_mp_count=64 (7-bit field holds 64 without overflow).
4. TIMEOUT=16: send 10 bytes, then idle 16 cycles -> timeout_err pulses once. A following full frame decodes as in scenario 1.
5. In S_HOLD send 2 bytes, then tx_ack in the same cycle as a third byte -> overrun=1, tx_n/tx_e unchanged, tx_valid low the next cycle. The next frame is accepted.
6. NUM_MSG=2, DBITS=64: two blocks -> writes at addr0 then addr1. Also assert rst mid-frame -> all outputs 0 immediately, and a following frame completes correctly.
